// File: rtl/mux_rr_reg.sv
// N-input registered multiplexer with valid/ready on every channel.
// Fixed-select or round-robin channel choice feeding one output register.
module mux_rr_reg #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int SEL_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mode,
   input  logic [SEL_W-1:0]   sel,
   input  logic [N*WIDTH-1:0] d,
   input  logic [N-1:0]       d_valid,
   output logic [N-1:0]       d_ready,
   output logic [WIDTH-1:0]   q,
   output logic               q_valid,
   input  logic               q_ready,
   output logic [SEL_W-1:0]   q_src
);

   // Result layout for the pick functions: {hit, index}.
   function automatic logic [SEL_W:0] fixed_pick(input logic [N-1:0] valid,
                                                 input logic [SEL_W-1:0] s);
      logic [SEL_W:0] res;
      res = '0;
      for (int i = 0; i < N; i++)
         if (i == int'(s)) res = {valid[i], SEL_W'(i)};
      return res;
   endfunction

   // Scan base, base+1, ... modulo N; walking backwards leaves the first hit.
   function automatic logic [SEL_W:0] rr_pick(input logic [N-1:0] valid,
                                              input logic [SEL_W-1:0] base);
      logic [SEL_W:0] res;
      int             idx;
      res = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(base) + k;
         if (idx >= N) idx = idx - N;
         for (int i = 0; i < N; i++)
            if (i == idx && valid[i]) res = {1'b1, SEL_W'(i)};
      end
      return res;
   endfunction

   function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx);
      if (int'(idx) >= N - 1) return '0;
      return idx + 1'b1;
   endfunction

   logic [WIDTH-1:0] data_p1;
   logic             vld_p1;
   logic [SEL_W-1:0] src_p1;
   logic [SEL_W-1:0] ptr;

   logic [SEL_W:0]   fx_res;
   logic [SEL_W:0]   rr_res;
   logic [SEL_W-1:0] grant;
   logic             hit;
   logic             free;
   logic             accept;
   logic [WIDTH-1:0] data_p0;

   // Stage 0: grant selection and accept, purely combinational.
   always_comb begin
      fx_res  = fixed_pick(d_valid, sel);
      rr_res  = rr_pick(d_valid, ptr);
      grant   = mode ? rr_res[SEL_W-1:0] : fx_res[SEL_W-1:0];
      hit     = mode ? rr_res[SEL_W] : fx_res[SEL_W];
      free    = !vld_p1 || q_ready;
      accept  = free && hit && !rst;
      d_ready = '0;
      data_p0 = '0;
      for (int i = 0; i < N; i++) begin
         if (i == int'(grant)) begin
            d_ready[i] = accept;
            data_p0    = d[i*WIDTH +: WIDTH];
         end
      end
   end

   // Stage 1: output register; async reset drops any held word at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_p1 <= '0;
         vld_p1  <= 1'b0;
         src_p1  <= '0;
         ptr     <= '0;
      end else if (accept) begin
         data_p1 <= data_p0;
         vld_p1  <= 1'b1;
         src_p1  <= grant;
         if (mode) ptr <= wrap_inc(grant);
      end else if (vld_p1 && q_ready) begin
         vld_p1  <= 1'b0;
      end
   end

   assign q       = data_p1;
   assign q_valid = vld_p1;
   assign q_src   = src_p1;

endmodule

// File: doc/mux_rr_reg.md
Name: mux_rr_reg

Overview:
- Parametrised N-input, WIDTH-bit multiplexer with a registered output stage and valid/ready handshakes on every input and on the output.
- Two selection modes:
  - Fixed select: an external `sel` port picks the input, as in the basic 2:1 mux.
  - Round-robin: the block arbitrates fairly among the inputs that are presenting valid data.
- Intended as the shared funnel that merges several producer streams onto one consumer in the course datapath.

Parameters:
- WIDTH, 8, data width of each input channel and of the output.
- N, 4, number of input channels (N >= 2; need not be a power of 2).
- SEL_W, $clog2(N), width of sel, q_src and the internal pointer. Derived only; never overridden.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = fixed select by sel, 1 = round-robin arbitration.
- sel  input  SEL_W  channel index used when mode=0.
- d  input  N*WIDTH  packed input data; channel i is d[i*WIDTH +: WIDTH].
- d_valid  input  N  per-channel data-valid.
- d_ready  output  N  per-channel accept strobe, combinational, at most one bit high.
- q  output  WIDTH  registered output data.
- q_valid  output  1  output register holds valid data.
- q_ready  input  1  consumer accepts q this cycle.
- q_src  output  SEL_W  index of the channel that produced the current q.

Behaviour:
- Reset (async, rst=1):
  - q=0, q_valid=0, q_src=0, round-robin pointer ptr=0.
  - Any held word is discarded immediately, not at the next clock edge.
  - d_ready=0 while rst=1.
- Slot free: free = !q_valid || q_ready. An input is accepted only when free=1.
- Grant, combinational:
  - mode=0: grant = sel. Valid only if sel < N and d_valid[sel]=1.
    - sel >= N (N not a power of 2): no grant, no accept, q path idles.
  - mode=1: grant = first index i with d_valid[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N wrap).
    - No valid channels: no grant.
- Accept:
  - d_ready[grant] = free && grant valid; all other d_ready bits are 0.
  - On the clock edge with accept: q <= d[grant], q_src <= grant, q_valid <= 1.
- Drain:
  - q_valid && q_ready with no accept in the same cycle: q_valid <= 0.
  - q and q_src hold their last values.
- Stall: q_valid=1 and q_ready=0.
  - q, q_src and q_valid hold.
  - All d_ready bits are 0; inputs must hold their data.
- Latency and throughput:
  - 1 cycle from accept to q_valid.
  - Simultaneous drain and accept gives back-to-back transfers, 1 word/cycle sustained.
- Pointer update:
  - mode=1 accept: ptr <= (grant+1) mod N. With N=3, grant=2 wraps to ptr=0.
  - mode=0, or no accept: ptr unchanged.
- Mode switch:
  - Applies combinationally to the next grant.
  - Does not disturb q, q_valid or ptr.
- Fairness (mode=1): with all channels continuously valid and q_ready=1, grants rotate 0,1,...,N-1,0,... No channel waits more than N-1 accepts.
- No combinational path from d or d_valid to q or q_valid. d_ready depends combinationally on q_ready, d_valid, mode, sel and ptr.

Test Plan (N=4, WIDTH=8 unless stated):
- Reset: assert rst mid-transfer with q_valid=1, q=8'hA5 -> q=0, q_valid=0 and d_ready=0 immediately, without a clock edge. After release: ptr=0, first RR grant goes to channel 0.
- Fixed mode: mode=0, sel=2, d_valid=4'b0100, d[2]=8'h3C, q_ready=1 -> d_ready=4'b0100. Next cycle: q=8'h3C, q_src=2, q_valid=1. Then sel=1 with d_valid[1]=0 -> d_ready=0, and q_valid drops after the drain.
- Round-robin rotation: mode=1, d_valid=4'b1111 held, d[i]=8'h10+i, q_ready=1 -> q sequence 8'h10, 11, 12, 13, 10, one per cycle, q_src 0,1,2,3,0.
- Skip and wrap: mode=1, ptr=3, d_valid=4'b0010 -> grant 1, ptr becomes 2. Next, d_valid=4'b0001 -> grant 0.
- Backpressure: q_valid=1, q_ready=0 for 3 cycles with d_valid=4'b1111 -> q, q_src and ptr stable, d_ready=0. When q_ready=1 in the same cycle, the next word is accepted and presented the following cycle, with no bubble.
- Non-power-of-2: N=3, mode=0, sel=3, d_valid=3'b111 -> no accept, q_valid stays 0. Under mode=1, grant 2 followed by an accept -> ptr wraps to 0.
